example_text_memory_arbiter: RTL and testbench

- Shares the single synchronous-read text memory between two requesters: instruction fetch (port F) and the debug/program-readback port (port D).
- Sits between the requesters and example_text_memory, in place of a direct single-master text bus.
- Grants at most one access per cycle and routes the 1-cycle-latency read data back to the owner.
- Flags out-of-range addresses deterministically and counts contention cycles.

---
 rtl/example_text_memory_arbiter_if.sv | 37 +++
 rtl/example_text_memory_arbiter.sv | 110 +++++++++++
 tb/tb_example_text_memory_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/example_text_memory_arbiter_if.sv
// Bundles the fetch port, the debug port and the text-memory bus.
// slave: the arbiter's view. master: the requesters' and memory's view.
interface example_text_memory_arbiter_if #(
  parameter int unsigned TEXT_BITS = 16
);
  logic                   f_req;
  logic [31:0]            f_addr;
  logic                   f_gnt;
  logic                   f_rvalid;
  logic [31:0]            f_rdata;
  logic                   f_err;

  logic                   d_req;
  logic [31:0]            d_addr;
  logic                   d_gnt;
  logic                   d_rvalid;
  logic [31:0]            d_rdata;
  logic                   d_err;

  logic                   mem_en;
  logic [TEXT_BITS-3:0]   mem_addr;
  logic [31:0]            mem_q;

  modport slave (
    input  f_req, f_addr, d_req, d_addr, mem_q,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_en, mem_addr
  );

  modport master (
    output f_req, f_addr, d_req, d_addr, mem_q,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_en, mem_addr
  );
endinterface

// File: rtl/example_text_memory_arbiter.sv
// Two-port (fetch F, debug D) arbiter in front of the 1-cycle-latency text memory.
// Define TEXT_ARB_ROUND_ROBIN_EN for round-robin; otherwise F has fixed priority.
module example_text_memory_arbiter #(
  parameter logic [31:0] TEXT_BEGIN = 32'h0040_0000,
  parameter int unsigned TEXT_BITS  = 16
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  example_text_memory_arbiter_if.slave   bus,
  output logic [15:0]                    o_conflict_count
);

  localparam logic [31:0] TEXT_END =
    TEXT_BEGIN + 32'((64'd1 << TEXT_BITS) - 64'd1);

  typedef enum logic {PORT_F = 1'b0, PORT_D = 1'b1} port_e;

  logic        w_gnt_f;
  logic        w_gnt_d;
  logic        w_any_gnt;
  logic        w_in_range;
  logic [31:0] w_addr;
  logic        w_own_f;
  logic        w_own_d;

  logic        r_rsp_valid;
  logic        r_rsp_err;
  port_e       r_rsp_port;
  logic [15:0] r_conflict_count;

`ifdef TEXT_ARB_ROUND_ROBIN_EN
  port_e       r_last_port;
`endif

  // Grant decision, combinational in the request cycle
  always_comb begin
    w_gnt_f = 1'b0;
    w_gnt_d = 1'b0;
    if (!i_reset) begin
`ifdef TEXT_ARB_ROUND_ROBIN_EN
      if (bus.f_req && bus.d_req) begin
        w_gnt_f = (r_last_port == PORT_D);
        w_gnt_d = (r_last_port == PORT_F);
      end else begin
        w_gnt_f = bus.f_req;
        w_gnt_d = bus.d_req;
      end
`else
      w_gnt_f = bus.f_req;
      w_gnt_d = bus.d_req && !bus.f_req;
`endif
    end
  end

  assign w_any_gnt  = w_gnt_f || w_gnt_d;
  assign w_addr     = w_gnt_f ? bus.f_addr : (w_gnt_d ? bus.d_addr : 32'h0);
  assign w_in_range = (w_addr >= TEXT_BEGIN) && (w_addr <= TEXT_END);

  assign bus.f_gnt    = w_gnt_f;
  assign bus.d_gnt    = w_gnt_d;
  assign bus.mem_en   = w_any_gnt && w_in_range;
  assign bus.mem_addr = w_any_gnt ? w_addr[TEXT_BITS-1:2] : '0;

  // Response tracking for the access granted last cycle
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_port  <= PORT_F;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_any_gnt;
      r_rsp_port  <= w_gnt_d ? PORT_D : PORT_F;
      r_rsp_err   <= !w_in_range;
    end
  end

`ifdef TEXT_ARB_ROUND_ROBIN_EN
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last_port <= PORT_D;
    end else if (w_gnt_f) begin
      r_last_port <= PORT_F;
    end else if (w_gnt_d) begin
      r_last_port <= PORT_D;
    end
  end
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_conflict_count <= 16'h0000;
    end else if (bus.f_req && bus.d_req && (r_conflict_count != 16'hFFFF)) begin
      r_conflict_count <= r_conflict_count + 16'd1;
    end
  end

  assign o_conflict_count = r_conflict_count;

  // A pending response is dropped as soon as reset is seen
  assign w_own_f = r_rsp_valid && (r_rsp_port == PORT_F) && !i_reset;
  assign w_own_d = r_rsp_valid && (r_rsp_port == PORT_D) && !i_reset;

  assign bus.f_rvalid = w_own_f;
  assign bus.f_err    = w_own_f && r_rsp_err;
  assign bus.f_rdata  = (w_own_f && !r_rsp_err) ? bus.mem_q : 32'h0;
  assign bus.d_rvalid = w_own_d;
  assign bus.d_err    = w_own_d && r_rsp_err;
  assign bus.d_rdata  = (w_own_d && !r_rsp_err) ? bus.mem_q : 32'h0;

endmodule

// File: tb/tb_example_text_memory_arbiter.sv
// Self-checking bench for example_text_memory_arbiter; follows TEXT_ARB_ROUND_ROBIN_EN.
module tb_example_text_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cnt;

  example_text_memory_arbiter_if #(.TEXT_BITS(16)) bus ();

  example_text_memory_arbiter #(
    .TEXT_BEGIN(32'h0040_0000),
    .TEXT_BITS (16)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .bus              (bus),
    .o_conflict_count (cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];

  // Synchronous-read text memory; idle cycles return a poison word
  always @(posedge clk) bus.mem_q <= bus.mem_en ? mem[bus.mem_addr] : 32'h0BAD0BAD;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= 32'h0040_0000) && (a <= 32'h0040_FFFF);
  endfunction

  // 0 = none, 1 = F, 2 = D
  function automatic int exp_grant(input logic fr, input logic dr, input logic r, input int last);
    if (r) return 0;
    if (fr && dr) begin
`ifdef TEXT_ARB_ROUND_ROBIN_EN
      return (last == 1) ? 2 : 1;
`else
      return 1;
`endif
    end
    if (fr) return 1;
    if (dr) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    logic [31:0] w;
    w = in_rng(a) ? mem[a[15:2]] : 32'h0;
    return w;
  endfunction

  // Model state: the access owed a response, last winner, contention count
  bit          m_started = 0;
  bit          m_pv = 0;
  int          m_pp = 0;
  logic [31:0] m_pa = 32'h0;
  int          m_last = 2;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_started <= 1;
      m_pv      <= 0;
      m_last    <= 2;
      m_cnt     <= 0;
    end else begin
      m_pv <= exp_grant(bus.f_req, bus.d_req, rst, m_last) != 0;
      m_pp <= exp_grant(bus.f_req, bus.d_req, rst, m_last);
      m_pa <= (exp_grant(bus.f_req, bus.d_req, rst, m_last) == 1) ? bus.f_addr :
              (exp_grant(bus.f_req, bus.d_req, rst, m_last) == 2) ? bus.d_addr : 32'h0;
      if (exp_grant(bus.f_req, bus.d_req, rst, m_last) != 0)
        m_last <= exp_grant(bus.f_req, bus.d_req, rst, m_last);
      if (bus.f_req && bus.d_req && m_cnt < 65535) m_cnt <= m_cnt + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_started) begin
      automatic int          g  = exp_grant(bus.f_req, bus.d_req, rst, m_last);
      automatic logic [31:0] ea = (g == 1) ? bus.f_addr : (g == 2) ? bus.d_addr : 32'h0;
      automatic bit          of = m_pv && (m_pp == 1) && !rst;
      automatic bit          od = m_pv && (m_pp == 2) && !rst;
      chk("f_gnt",    32'(bus.f_gnt),    32'(g == 1));
      chk("d_gnt",    32'(bus.d_gnt),    32'(g == 2));
      chk("mem_en",   32'(bus.mem_en),   32'((g != 0) && in_rng(ea)));
      chk("mem_addr", 32'(bus.mem_addr), (g != 0) ? 32'(ea[15:2]) : 32'h0);
      chk("f_rvalid", 32'(bus.f_rvalid), 32'(of));
      chk("f_err",    32'(bus.f_err),    32'(of && !in_rng(m_pa)));
      chk("f_rdata",  bus.f_rdata,       of ? exp_data(m_pa) : 32'h0);
      chk("d_rvalid", 32'(bus.d_rvalid), 32'(od));
      chk("d_err",    32'(bus.d_err),    32'(od && !in_rng(m_pa)));
      chk("d_rdata",  bus.d_rdata,       od ? exp_data(m_pa) : 32'h0);
      chk("conflict_count", 32'(cnt),    32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = {16'(i) ^ 16'h5A5A, ~16'(i)};
    mem[2]        = 32'hDEAD_BEEF;
    mem[14'h3FFF] = 32'hCAFE_F00D;
    bus.f_req = 0; bus.f_addr = 32'h0;
    bus.d_req = 0; bus.d_addr = 32'h0;

    // Reset then idle
    step(); step();
    rst = 0;
    @(negedge clk);
    chk("lit_idle_gnt",    32'({bus.f_gnt, bus.d_gnt}), 32'h0);
    chk("lit_idle_rvalid", 32'({bus.f_rvalid, bus.d_rvalid, bus.f_err, bus.d_err}), 32'h0);
    chk("lit_idle_rdata",  bus.f_rdata | bus.d_rdata, 32'h0);
    chk("lit_idle_cnt",    32'(cnt), 32'h0);
    chk("lit_idle_mem_en", 32'(bus.mem_en), 32'h0);

    // Single fetch
    bus.f_req = 1; bus.f_addr = 32'h0040_0008;
    @(negedge clk);
    chk("lit_fetch_gnt",    32'(bus.f_gnt), 32'h1);
    chk("lit_fetch_mem_en", 32'(bus.mem_en), 32'h1);
    chk("lit_fetch_addr",   32'(bus.mem_addr), 32'h2);
    step(); bus.f_req = 0;
    @(negedge clk);
    chk("lit_fetch_rvalid", 32'(bus.f_rvalid), 32'h1);
    chk("lit_fetch_rdata",  bus.f_rdata, 32'hDEAD_BEEF);
    chk("lit_fetch_err",    32'(bus.f_err), 32'h0);
    chk("lit_fetch_d_rv",   32'(bus.d_rvalid), 32'h0);

    // Out of range on D, then the last in-range word
    bus.d_req = 1; bus.d_addr = 32'h0041_0000;
    @(negedge clk);
    chk("lit_oor_gnt",    32'(bus.d_gnt), 32'h1);
    chk("lit_oor_mem_en", 32'(bus.mem_en), 32'h0);
    step(); bus.d_addr = 32'h003F_FFFC;
    @(negedge clk);
    chk("lit_oor_hi_rv",  32'({bus.d_rvalid, bus.d_err}), 32'h3);
    chk("lit_oor_hi_dat", bus.d_rdata, 32'h0);
    chk("lit_oor_lo_men", 32'(bus.mem_en), 32'h0);
    step(); bus.d_addr = 32'h0040_FFFC;
    @(negedge clk);
    chk("lit_oor_lo_err", 32'({bus.d_rvalid, bus.d_err}), 32'h3);
    chk("lit_last_men",   32'(bus.mem_en), 32'h1);
    step(); bus.d_req = 0;
    @(negedge clk);
    chk("lit_last_err",   32'({bus.d_rvalid, bus.d_err}), 32'h2);
    chk("lit_last_data",  bus.d_rdata, 32'hCAFE_F00D);

    bus.f_req = 1; bus.f_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("lit_top_men", 32'(bus.mem_en), 32'h0);
    step(); bus.f_req = 0;
    @(negedge clk);
    chk("lit_top_err", 32'({bus.f_rvalid, bus.f_err}), 32'h3);
    chk("lit_top_dat", bus.f_rdata, 32'h0);

    // Contention, four cycles right after reset
    rst = 1; step(); rst = 0;
    bus.f_req = 1; bus.f_addr = 32'h0040_0010;
    bus.d_req = 1; bus.d_addr = 32'h0040_0020;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef TEXT_ARB_ROUND_ROBIN_EN
      chk("lit_cont_gnt", 32'({bus.f_gnt, bus.d_gnt}), (i % 2 == 0) ? 32'h2 : 32'h1);
`else
      chk("lit_cont_gnt", 32'({bus.f_gnt, bus.d_gnt}), 32'h2);
`endif
      step();
    end
    bus.f_req = 0; bus.d_req = 0;
    @(negedge clk);
    chk("lit_cont_cnt", 32'(cnt), 32'd4);
`ifdef TEXT_ARB_ROUND_ROBIN_EN
    chk("lit_cont_last_rv", 32'({bus.f_rvalid, bus.d_rvalid}), 32'h1);
`else
    chk("lit_cont_last_rv", 32'({bus.f_rvalid, bus.d_rvalid}), 32'h2);
`endif

    // Reset in the cycle after a grant drops the response
    step();
    bus.f_req = 1; bus.f_addr = 32'h0040_0008;
    @(negedge clk);
    chk("lit_mid_gnt", 32'(bus.f_gnt), 32'h1);
    step(); bus.f_req = 0; rst = 1;
    @(negedge clk);
    chk("lit_mid_rv_n1", 32'(bus.f_rvalid), 32'h0);
    step(); rst = 0;
    @(negedge clk);
    chk("lit_mid_rv_n2", 32'(bus.f_rvalid), 32'h0);

    // Saturation of the contention counter
    bus.f_req = 1; bus.d_req = 1;
    bus.f_addr = 32'h0040_0100; bus.d_addr = 32'h0040_0200;
    for (int i = 0; i < 65540; i++) step();
    bus.f_req = 0; bus.d_req = 0;
    @(negedge clk);
    chk("lit_sat_cnt", 32'(cnt), 32'h0000_FFFF);
    step();
    @(negedge clk);
    chk("lit_sat_hold", 32'(cnt), 32'h0000_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
